// File: rtl/mul_seq_arbiter_if.sv
// Handshake bundle for mul_seq_arbiter: two operand requesters and one
// product consumer. "master" is the requester/consumer side, "slave" the
// arbiter/multiplier side.
interface mul_seq_arbiter_if #(
  parameter int WIDTH = 8
);
  logic               req0_valid;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;
  logic               req0_ready;
  logic               req1_valid;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;
  logic               req1_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [2*WIDTH-1:0] rsp_prod;
  logic               rsp_id;

  modport master (
    output req0_valid, req0_a, req0_b, input req0_ready,
    output req1_valid, req1_a, req1_b, input req1_ready,
    input  rsp_valid, rsp_prod, rsp_id, output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, output req0_ready,
    input  req1_valid, req1_a, req1_b, output req1_ready,
    output rsp_valid, rsp_prod, rsp_id, input rsp_ready
  );
endinterface

// File: rtl/mul_seq_arbiter.sv
// Two-requester arbiter in front of one shift-add multiplier.
//
// state | meaning
// IDLE  | waiting; ready granted to one valid requester (round-robin on tie)
// RUN   | one shift-add step per cycle, WIDTH steps (fewer with early exit)
// DONE  | product held on rsp_* until the consumer takes it
//
// Optional feature: define MUL_SEQ_EARLY_EXIT_EN to leave RUN as soon as the
// remaining multiplier bits are all zero. Default build always runs WIDTH steps.
module mul_seq_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  mul_seq_arbiter_if.slave    bus,
  output logic                busy
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    sum;
  logic [PW-1:0]    prod_q;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             op_id;
  logic             ptr;
  logic             id_q;
  logic             valid_q;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             last;

  // Grant: a sole valid wins; with both valid the pointer decides.
  always_comb begin
    grant0 = bus.req0_valid && (!bus.req1_valid || !ptr);
    grant1 = bus.req1_valid && (!bus.req0_valid || ptr);
  end

  assign bus.req0_ready = (state == IDLE) && !rst && grant0;
  assign bus.req1_ready = (state == IDLE) && !rst && grant1;
  assign accept         = bus.req0_ready || bus.req1_ready;

  // The single shared adder of the datapath.
  assign sum = mplier[0] ? (acc + mcand) : acc;

`ifdef MUL_SEQ_EARLY_EXIT_EN
  assign last = (cnt == CW'(WIDTH - 1)) || ((mplier >> 1) == '0);
`else
  assign last = (cnt == CW'(WIDTH - 1));
`endif

  assign bus.rsp_valid = valid_q;
  assign bus.rsp_prod  = prod_q;
  assign bus.rsp_id    = id_q;
  assign busy          = (state != IDLE);

  // Sequencer and datapath; response outputs are registered and cleared
  // whenever no response is being offered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      op_id   <= 1'b0;
      ptr     <= 1'b0;
      valid_q <= 1'b0;
      prod_q  <= '0;
      id_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= PW'(bus.req1_ready ? bus.req1_a : bus.req0_a);
            mplier <= bus.req1_ready ? bus.req1_b : bus.req0_b;
            op_id  <= bus.req1_ready;
            ptr    <= !bus.req1_ready;
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            valid_q <= 1'b1;
            prod_q  <= sum;
            id_q    <= op_id;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            valid_q <= 1'b0;
            prod_q  <= '0;
            id_q    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_seq_arbiter.sv
// Bench for mul_seq_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_mul_seq_arbiter;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  mul_seq_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mul_seq_arbiter #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Number of RUN cycles an operation with multiplier b must take.
  function automatic int run_len(logic [7:0] b);
    int n;
    n = 8;
`ifdef MUL_SEQ_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < 8; i++) if (b[i]) n = i + 1;
`endif
    return n;
  endfunction

  // Reference model: queue of accepted operations in order, plus a countdown
  // of RUN cycles left and a flag for "response being offered".
  typedef struct {
    logic [15:0] prod;
    logic        id;
  } op_t;

  op_t         exp_q[$];
  int          m_cnt  = 0;
  bit          m_done = 1'b0;
  bit          m_ptr  = 1'b0;
  logic [15:0] log_prod[$];
  logic        log_id[$];

  always @(negedge clk) begin
    bit          idle;
    bit          e_r0;
    bit          e_r1;
    logic [15:0] e_prod;
    logic        e_id;
    idle   = (m_cnt == 0) && !m_done;
    e_r0   = !rst && idle && bus.req0_valid && (!bus.req1_valid || !m_ptr);
    e_r1   = !rst && idle && bus.req1_valid && (!bus.req0_valid || m_ptr);
    e_prod = m_done ? exp_q[0].prod : 16'h0;
    e_id   = m_done ? exp_q[0].id : 1'b0;
    check("req0_ready", bus.req0_ready, e_r0);
    check("req1_ready", bus.req1_ready, e_r1);
    check("busy", busy, !idle);
    check("rsp_valid", bus.rsp_valid, m_done);
    check("rsp_prod", bus.rsp_prod, e_prod);
    check("rsp_id", bus.rsp_id, e_id);
    if (rst) begin
      m_cnt  = 0;
      m_done = 1'b0;
      m_ptr  = 1'b0;
      exp_q.delete();
    end else if (idle) begin
      if (e_r0 || e_r1) begin
        op_t        o;
        logic [7:0] a;
        logic [7:0] b;
        a      = e_r1 ? bus.req1_a : bus.req0_a;
        b      = e_r1 ? bus.req1_b : bus.req0_b;
        o.prod = 16'(a) * 16'(b);
        o.id   = e_r1;
        exp_q.push_back(o);
        m_cnt  = run_len(b);
        m_ptr  = !e_r1;
        n_vec++;
      end
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) m_done = 1'b1;
    end else if (bus.rsp_ready) begin
      log_prod.push_back(bus.rsp_prod);
      log_id.push_back(bus.rsp_id);
      void'(exp_q.pop_front());
      m_done = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit id, input logic [7:0] a, input logic [7:0] b, output int t);
    t = -1;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
    end
    for (int i = 0; i < 60 && t < 0; i++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) t = cyc;
      step();
    end
    // Scramble operands after accept; the running product must not notice.
    if (id) begin
      bus.req1_valid = 1'b0; bus.req1_a = ~a; bus.req1_b = ~b;
    end else begin
      bus.req0_valid = 1'b0; bus.req0_a = ~a; bus.req0_b = ~b;
    end
    if (t < 0) check("send_timeout", 1, 0);
  endtask

  task automatic wait_rsp(output int t, output logic [15:0] p, output logic id);
    t  = -1;
    p  = '0;
    id = 1'b0;
    for (int i = 0; i < 60 && t < 0; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        t  = cyc;
        p  = bus.rsp_prod;
        id = bus.rsp_id;
      end
    end
    if (t < 0) check("rsp_timeout", 1, 0);
  endtask

  task automatic drain();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    for (int i = 0; i < 200 && busy; i++) step();
    check("drain_busy", busy, 0);
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h01;
      3: return 8'h80;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  int          t_acc;
  int          t_rsp;
  logic [15:0] r_prod;
  logic        r_id;
  int          start;
  int          target;

  initial begin
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 1'b1;

    // Reset state, with a requester knocking during reset.
    repeat (2) step();
    bus.req0_valid = 1'b1;
    step();
    check("rst_ready0", bus.req0_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_prod", bus.rsp_prod, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    bus.req0_valid = 1'b0;
    rst = 1'b0;
    step();

    // Single request 0x0C * 0x0A.
    send(1'b0, 8'h0C, 8'h0A, t_acc);
    wait_rsp(t_rsp, r_prod, r_id);
`ifdef MUL_SEQ_EARLY_EXIT_EN
    check("t1_latency", t_rsp - t_acc, 5);
`else
    check("t1_latency", t_rsp - t_acc, 9);
`endif
    check("t1_prod", r_prod, 16'h0078);
    check("t1_id", r_id, 0);
    step();
    drain();

    // Both requesters valid continuously: grants alternate from requester 0.
    rst = 1'b1; step(); rst = 1'b0; step();
    start = log_prod.size();
    bus.req0_a = 8'd3;  bus.req0_b = 8'd5;
    bus.req1_a = 8'hFF; bus.req1_b = 8'hFF;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 200 && log_prod.size() < start + 4; i++) step();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    check("rr_count", log_prod.size() >= start + 4, 1);
    if (log_prod.size() >= start + 4) begin
      for (int k = 0; k < 4; k++) begin
        check("rr_id", log_id[start + k], k % 2);
        check("rr_prod", log_prod[start + k], (k % 2) ? 16'hFE01 : 16'h000F);
      end
    end
    drain();

    // Consumer stalls for 5 cycles in DONE.
    bus.rsp_ready = 1'b0;
    send(1'b0, 8'd3, 8'd7, t_acc);
    wait_rsp(t_rsp, r_prod, r_id);
    step();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", bus.rsp_valid, 1);
      check("stall_prod", bus.rsp_prod, 16'h0015);
      check("stall_id", bus.rsp_id, 0);
      check("stall_ready0", bus.req0_ready, 0);
      check("stall_ready1", bus.req1_ready, 0);
      check("stall_busy", busy, 1);
      step();
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    step();
    check("release_busy", busy, 0);
    check("release_valid", bus.rsp_valid, 0);
    check("release_prod", bus.rsp_prod, 0);

    // Reset in RUN cycle 4 abandons the operation.
    send(1'b1, 8'h09, 8'hFF, t_acc);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", bus.rsp_valid, 0);
    check("abort_prod", bus.rsp_prod, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("abort_no_rsp", bus.rsp_valid, 0);
    end
    step();
    bus.req0_a = 8'd2; bus.req0_b = 8'd2; bus.req1_a = 8'd4; bus.req1_b = 8'd4;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    @(negedge clk);
    check("abort_next_ready0", bus.req0_ready, 1);
    check("abort_next_ready1", bus.req1_ready, 0);
    step();
    drain();

    // Multiplier of one: early exit shortens the run.
    send(1'b1, 8'h55, 8'h01, t_acc);
    wait_rsp(t_rsp, r_prod, r_id);
`ifdef MUL_SEQ_EARLY_EXIT_EN
    check("ee_latency", t_rsp - t_acc, 2);
`else
    check("ee_latency", t_rsp - t_acc, 9);
`endif
    check("ee_prod", r_prod, 16'h0055);
    check("ee_id", r_id, 1);
    step();
    drain();

    // Random traffic with stalls on both sides.
    target = n_vec + 1000;
    for (int i = 0; i < 40000 && n_vec < target; i++) begin
      bus.req0_valid = ($urandom_range(0, 99) < 60);
      bus.req1_valid = ($urandom_range(0, 99) < 60);
      bus.req0_a = pick(); bus.req0_b = pick();
      bus.req1_a = pick(); bus.req1_b = pick();
      bus.rsp_ready = ($urandom_range(0, 99) < 65);
      step();
    end
    check("random_done", n_vec >= target, 1);
    drain();
    check("random_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
